rgb_led_sequencer: RTL and testbench
====================================

# rgb_led_sequencer

Generates the three PWM enables for the board's RGB LED current driver from the two DIP switches. Debounces BS1/BS2 into a 2-bit mode and runs an off / solid / blink / breathe light pattern with an 8-bit PWM per channel. Sits between the switch pins and the RGB0PWM..RGB2PWM inputs of the SB_RGBA_DRV primitive in the top level; the driver itself stays in the top.

## Interface
- DEBOUNCE_CYCLES, 12000: consecutive stable cycles needed to accept a switch change (1 ms at 12 MHz); must be ≥ 1.
- STEP_DIV, 46875: CLK12 cycles per pattern step; must be ≥ 1.

- CLK12  in  1  system clock, 12 MHz; the block's only clock.
- RSTN  in  1  asynchronous, active-low reset.
- BS1  in  1  DIP switch 1, asynchronous, mode bit 0.
- BS2  in  1  DIP switch 2, asynchronous, mode bit 1.
- PWM0  out  1  red PWM enable, to RGB0PWM.
- PWM1  out  1  green PWM enable, to RGB1PWM.
- PWM2  out  1  blue PWM enable, to RGB2PWM.
- MODE  out  2  debounced mode {BS2,BS1}.

## Operation
- Input path: each switch passes through a 2-flop synchroniser, then a shared debounce counter. If the synchronised pair differs from MODE, the counter increments. If it matches, the counter clears. When the counter reaches DEBOUNCE_CYCLES−1 while still differing, MODE loads the pair and the counter clears.
- Any MODE update (mode restart) clears the brightness B (8 bit) to 0, sets direction UP, sets colour index C to 0 (red), and clears the step prescaler.
- Step tick: the prescaler counts 0..STEP_DIV−1 and wraps. A one-cycle tick fires on the wrap.
- PWM: an 8-bit counter P is free-running and wraps 255→0. A channel is on when P < duty. Duty 0 means always off; duty 255 gives 255/256.
- Mode 00, OFF: all duties 0.
- Mode 01, SOLID: red duty 255; green and blue 0.
- Mode 10, BLINK:
  - On each tick, B increments and wraps 255→0.
  - All three duties are 255 while B[7]=0 and 0 while B[7]=1.
  - Period is 256 ticks; the LED starts white.
- Mode 11, BREATHE:
  - States UP/DOWN.
  - UP: each tick B += 1. At B=255, the next tick moves to DOWN and B = 254.
  - DOWN: each tick B −= 1. At B=0, the next tick moves to UP, sets B = 1, and sets C = (C+1) mod 3 (R→G→B→R).
  - The channel selected by C gets duty = f(B); the other two get 0.
  - B never wraps in BREATHE.
- f(B) = B unless the gamma option is compiled in (see Configuration).

## Timing
- Reset values: PWM0/1/2 = 0, MODE = 00, B = 0, direction UP, C = 0, P = 0, prescaler = 0, debounce counter = 0, synchronisers = 0.
- Switch-to-MODE latency: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles of stable input.
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes MODE.
- PWM outputs are registered: a duty or P value at edge n is reflected on PWMx after edge n+1.
- Mode restart and a tick in the same cycle: the restart wins and the tick is discarded.
- RSTN assertion mid-pattern forces all reset values immediately, regardless of clock. Release is expected synchronous to CLK12 at board level.

## Configuration
- RGB_SEQ_GAMMA_EN:
  - Defined: f(B) = (B*B) >> 8, using a 16-bit product and keeping the upper byte, for a perceptual fade. f(255) = 254 and f(0) = 0.
  - Undefined: f(B) = B (linear).
- Applies to BREATHE only; OFF, SOLID and BLINK duties are unaffected.

## Test plan
Parameters for the bench: DEBOUNCE_CYCLES=4, STEP_DIV=2.
- Reset then BS1=BS2=0 -> MODE=00, PWM0..2 held 0 for 1000 cycles.
- BS1=1 held -> MODE=01 exactly 6 cycles after the input edge. PWM0 high 255 of every 256 cycles; PWM1 and PWM2 stay 0.
- BS1 pulsed high for 3 cycles from MODE=00 -> MODE stays 00 and all PWMs stay 0.
- Mode 11 -> B ramps 0..255..0 over 510 ticks (1020 cycles). Only PWM0 toggles during the first cycle, then only PWM1, then PWM2, then PWM0 again.
- Mode 10 -> all three PWMs active for 256 cycles (128 ticks), then all low for 256 cycles, repeating.
- RSTN low mid-BREATHE, with C=2 and B=100 -> all outputs 0 and MODE=00 asynchronously. After release with BS=11, BREATHE restarts at red with B=0.

Source files
------------

// File: rtl/rgb_led_sequencer.sv
// -----------------------------------------------------------------------------
// rgb_led_sequencer
//
// Turns the two DIP switches into a debounced 2-bit mode and drives the three
// PWM enables for the SB_RGBA_DRV current driver (the driver stays in the top
// level) with one of four light patterns:
//   00 OFF, 01 SOLID red, 10 BLINK white, 11 BREATHE (R -> G -> B fade).
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive differing cycles needed to accept a switch
//                     change (>= 1)
//   STEP_DIV        : CLK12 cycles per pattern step (>= 1)
//
// Ports
//   CLK12  in   system clock (12 MHz), the only clock
//   RSTN   in   asynchronous active-low reset
//   BS1    in   DIP switch 1 (mode bit 0), asynchronous
//   BS2    in   DIP switch 2 (mode bit 1), asynchronous
//   PWM0   out  red PWM enable   (to RGB0PWM)
//   PWM1   out  green PWM enable (to RGB1PWM)
//   PWM2   out  blue PWM enable  (to RGB2PWM)
//   MODE   out  debounced mode {BS2,BS1}
//
// Optional feature macro
//   RGB_SEQ_GAMMA_EN : when defined, BREATHE duty is (B*B)>>8 instead of B.
// -----------------------------------------------------------------------------
module rgb_led_sequencer #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int STEP_DIV        = 46875
) (
  input  logic       CLK12,
  input  logic       RSTN,
  input  logic       BS1,
  input  logic       BS2,
  output logic       PWM0,
  output logic       PWM1,
  output logic       PWM2,
  output logic [1:0] MODE
);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_SOLID   = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Counters only need to hold 0..N-1.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);

  logic [1:0]      r_bs_meta;
  logic [1:0]      r_bs_sync;
  logic [1:0]      r_mode;
  logic [DB_W-1:0] r_db_cnt;
  logic [PS_W-1:0] r_pre;
  logic [7:0]      r_b;
  logic            r_dir;
  logic [1:0]      r_c;
  logic [7:0]      r_p;
  logic [2:0]      r_pwm;

  logic            w_differs;
  logic            w_restart;
  logic            w_tick;
  logic [7:0]      w_fb;
  logic [2:0][7:0] w_duty;
  logic [2:0]      w_pwm_next;

  // Any difference counts toward acceptance, even if the differing value
  // itself changes during the window; the last synchronised value is loaded.
  assign w_differs = (r_bs_sync != r_mode);
  assign w_restart = w_differs && (r_db_cnt == DB_LAST);
  // A restart in the same cycle as a prescaler wrap swallows the tick.
  assign w_tick    = (r_pre == PS_LAST) && !w_restart;

  // Switch synchronisers and shared debounce counter.
  always_ff @(posedge CLK12 or negedge RSTN) begin
    if (!RSTN) begin
      r_bs_meta <= 2'b00;
      r_bs_sync <= 2'b00;
      r_mode    <= MODE_OFF;
      r_db_cnt  <= '0;
    end else begin
      r_bs_meta <= {BS2, BS1};
      r_bs_sync <= r_bs_meta;
      if (w_restart) begin
        r_mode   <= r_bs_sync;
        r_db_cnt <= '0;
      end else if (w_differs) begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Step prescaler and pattern state (brightness, breathe direction, colour).
  always_ff @(posedge CLK12 or negedge RSTN) begin
    if (!RSTN) begin
      r_pre <= '0;
      r_b   <= 8'd0;
      r_dir <= DIR_UP;
      r_c   <= 2'd0;
    end else if (w_restart) begin
      r_pre <= '0;
      r_b   <= 8'd0;
      r_dir <= DIR_UP;
      r_c   <= 2'd0;
    end else begin
      r_pre <= (r_pre == PS_LAST) ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        case (r_mode)
          MODE_BLINK: r_b <= r_b + 8'd1;
          MODE_BREATHE: begin
            // Turn around at the ends without wrapping; colour advances
            // when the fade bottoms out.
            if (r_dir == DIR_UP) begin
              if (r_b == 8'hFF) begin
                r_dir <= DIR_DOWN;
                r_b   <= 8'hFE;
              end else begin
                r_b <= r_b + 8'd1;
              end
            end else begin
              if (r_b == 8'h00) begin
                r_dir <= DIR_UP;
                r_b   <= 8'd1;
                r_c   <= (r_c == 2'd2) ? 2'd0 : r_c + 2'd1;
              end else begin
                r_b <= r_b - 8'd1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef RGB_SEQ_GAMMA_EN
  logic [15:0] w_sq;
  assign w_sq = {8'd0, r_b} * {8'd0, r_b};
  assign w_fb = w_sq[15:8];
`else
  assign w_fb = r_b;
`endif

  // Per-channel duty selection and PWM compare.
  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    localparam logic [7:0] SOLID_DUTY = (gi == 0) ? 8'hFF : 8'h00;
    assign w_duty[gi] =
      (r_mode == MODE_SOLID)                          ? SOLID_DUTY :
      (r_mode == MODE_BLINK)                          ? (r_b[7] ? 8'h00 : 8'hFF) :
      ((r_mode == MODE_BREATHE) && (r_c == 2'(gi)))   ? w_fb :
                                                        8'h00;
    assign w_pwm_next[gi] = (r_p < w_duty[gi]);
  end

  // Free-running PWM counter and registered enables.
  always_ff @(posedge CLK12 or negedge RSTN) begin
    if (!RSTN) begin
      r_p   <= 8'd0;
      r_pwm <= 3'b000;
    end else begin
      r_p   <= r_p + 8'd1;
      r_pwm <= w_pwm_next;
    end
  end

  assign PWM0 = r_pwm[0];
  assign PWM1 = r_pwm[1];
  assign PWM2 = r_pwm[2];
  assign MODE = r_mode;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rgb_led_sequencer
//
// Scoreboard bench for rgb_led_sequencer (DEBOUNCE_CYCLES=4, STEP_DIV=2).
// A reference model, clocked alongside the DUT, derives every cycle's expected
// {MODE,PWM2,PWM1,PWM0} from the switch history and the elapsed step count and
// queues it; a separate monitor pops and compares on the falling edge.
// Honours RGB_SEQ_GAMMA_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_rgb_led_sequencer;

  localparam int D  = 4;
  localparam int SD = 2;

  logic       CLK12 = 1'b0;
  logic       RSTN  = 1'b0;
  logic       BS1   = 1'b0;
  logic       BS2   = 1'b0;
  logic       PWM0;
  logic       PWM1;
  logic       PWM2;
  logic [1:0] MODE;

  always #5 CLK12 = ~CLK12;

  rgb_led_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .STEP_DIV       (SD)
  ) dut (
    .CLK12(CLK12),
    .RSTN (RSTN),
    .BS1  (BS1),
    .BS2  (BS2),
    .PWM0 (PWM0),
    .PWM1 (PWM1),
    .PWM2 (PWM2),
    .MODE (MODE)
  );

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];

  // Reference model state
  int         m_n;             // edges since reset release
  int         m_load_edge;     // edge of last MODE load (0 = reset)
  int         m_restart_edge;  // edge the pattern last restarted
  logic [1:0] m_mode;
  logic [1:0] m_bs_at [0:65535];
  int         m_prev_p;
  int         m_prev_duty [3];
  int         m_b;
  int         m_c;

  // Synchronised switch value held after edge j.
  function automatic logic [1:0] sync_after(int j);
    if (j < 2) return 2'b00;
    return m_bs_at[j-1];
  endfunction

  function automatic int shape(int b);
`ifdef RGB_SEQ_GAMMA_EN
    return (b * b) >> 8;
`else
    return b;
`endif
  endfunction

  // Triangle wave 0..255..0 with period 510 steps.
  function automatic int tri_wave(int k);
    int r;
    r = k % 510;
    return (r <= 255) ? r : 510 - r;
  endfunction

  task automatic model_reset();
    m_n            = 0;
    m_load_edge    = 0;
    m_restart_edge = 0;
    m_mode         = 2'b00;
    m_prev_p       = 0;
    for (int i = 0; i < 3; i++) m_prev_duty[i] = 0;
    m_b = -1;
    m_c = -1;
  endtask

  // Reference model
  initial begin : model
    logic       load;
    logic [4:0] e;
    int         k;
    int         duty [3];
    model_reset();
    forever begin
      @(posedge CLK12);
      if (!RSTN) begin
        model_reset();
        exp_q.push_back(5'b0);
      end else begin
        m_n++;
        m_bs_at[m_n] = {BS2, BS1};
        // MODE loads once the last D synchronised samples since the previous
        // load all differ from the current mode.
        load = 1'b0;
        if (m_n - m_load_edge >= D) begin
          load = 1'b1;
          for (int j = m_n - D; j < m_n; j++)
            if (sync_after(j) == m_mode) load = 1'b0;
        end
        if (load) begin
          m_mode         = sync_after(m_n - 1);
          m_load_edge    = m_n;
          m_restart_edge = m_n;
        end
        // Outputs after this edge reflect P and duty from the previous edge.
        e = {m_mode,
             1'(m_prev_p < m_prev_duty[2]),
             1'(m_prev_p < m_prev_duty[1]),
             1'(m_prev_p < m_prev_duty[0])};
        exp_q.push_back(e);

        k = (m_n - m_restart_edge) / SD;
        for (int i = 0; i < 3; i++) duty[i] = 0;
        m_b = -1;
        m_c = -1;
        case (m_mode)
          2'b01: duty[0] = 255;
          2'b10: begin
            for (int i = 0; i < 3; i++) duty[i] = ((k % 256) < 128) ? 255 : 0;
          end
          2'b11: begin
            m_b = tri_wave(k);
            m_c = (k == 0) ? 0 : ((k - 1) / 510) % 3;
            duty[m_c] = shape(m_b);
          end
          default: begin
          end
        endcase
        m_prev_p = m_n % 256;
        for (int i = 0; i < 3; i++) m_prev_duty[i] = duty[i];
      end
    end
  end

  // Monitor
  initial begin : monitor
    logic [4:0] e;
    logic [4:0] act;
    forever begin
      @(negedge CLK12);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        if (!RSTN) e = 5'b0;
        act = {MODE, PWM2, PWM1, PWM0};
        checks++;
        if (act !== e) begin
          errors++;
          if (errors <= 20)
            $display("FAIL cycle t=%0t {MODE,PWM2,PWM1,PWM0} got %b expected %b",
                     $time, act, e);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge CLK12);
    #2;
  endtask

  task automatic segment(logic [1:0] v, int hold, string tag);
    {BS2, BS1} = v;
    $display("seg %-8s BS=%b hold=%0d t=%0t", tag, v, hold, $time);
    step(hold);
  endtask

  // Stimulus
  initial begin : stim
    int lat;
    logic [1:0] v;
    int hold;
    bit found;

    {BS2, BS1} = 2'b00;
    RSTN = 1'b0;
    step(3);
    RSTN = 1'b1;

    segment(2'b00, 1000, "off");

    // Debounce latency from switch edge to MODE
    {BS2, BS1} = 2'b01;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK12);
      #1;
      if (MODE == 2'b01) begin
        lat = i;
        break;
      end
    end
    #1;
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL latency MODE=01 after %0d edges, expected 6", lat);
    end
    $display("seg latency BS=01 edges=%0d t=%0t", lat, $time);
    step(600);

    segment(2'b00, 20, "off");
    segment(2'b01, 3, "glitch");
    segment(2'b00, 50, "off");
    segment(2'b11, 3200, "breathe");
    segment(2'b10, 1100, "blink");

    // Reset in the middle of BREATHE at blue, B=100
    {BS2, BS1} = 2'b11;
    $display("seg breathe BS=11 until C=2 B=100 t=%0t", $time);
    found = 0;
    for (int i = 0; i < 6000; i++) begin
      step(1);
      if (m_mode == 2'b11 && m_c == 2 && m_b == 100) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_c2_b100 not reached within 6000 cycles, expected reached");
    end
    RSTN = 1'b0;
    #1;
    checks++;
    if (MODE !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_mode got %b expected 00", MODE);
    end
    checks++;
    if ({PWM2, PWM1, PWM0} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_pwm got %b expected 000", {PWM2, PWM1, PWM0});
    end
    $display("seg reset mid-breathe t=%0t", $time);
    step(3);
    RSTN = 1'b1;
    segment(2'b11, 1100, "restart");

    // Random switch activity: short glitches and long holds
    for (int s = 0; s < 40; s++) begin
      v    = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 700))
                                         : int'($urandom_range(1, 8));
      segment(v, hold, "random");
    end

    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
